// File: rtl/alu_result_demux_pkg.sv
// Shared definitions for the ALU result demultiplexer.
// Path encodings and slot state encoding used by top and slot.
package alu_result_demux_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic PATH_WB  = 1'b0;
    localparam logic PATH_MEM = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_demux_slot.sv
// One-entry registered output slot with fill/drain/flush control.
// can_accept is high when the slot is empty or draining this cycle.
module alu_demux_slot
    import alu_result_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_fill,
    input  logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_accept
);

    slot_state_e      r_state;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    assign o_valid      = (r_state == SLOT_FULL);
    assign o_data       = r_data;
    assign w_drain      = o_valid && i_ready;
    assign o_can_accept = !o_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else if (i_flush) begin
            r_state <= SLOT_EMPTY;
        end else begin
            unique case (r_state)
                SLOT_EMPTY: begin
                    if (i_fill) begin
                        r_state <= SLOT_FULL;
                        r_data  <= i_data;
                    end
                end
                SLOT_FULL: begin
                    // A fill while draining replaces the word in place.
                    if (i_fill) begin
                        r_data <= i_data;
                    end else if (w_drain) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_demux.sv
// Routes each ALU result word to the writeback or memory path.
// Each path owns an independent one-entry slot and handshake.
module alu_result_demux
    import alu_result_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    logic w_acc0;
    logic w_acc1;
    logic w_xfer;
    logic w_fill0;
    logic w_fill1;

    // Ready depends only on sel, flush and consumer readiness.
    assign in_ready = !flush && ((in_sel == PATH_MEM) ? w_acc1 : w_acc0);
    assign w_xfer   = in_valid && in_ready;
    assign w_fill0  = w_xfer && (in_sel == PATH_WB);
    assign w_fill1  = w_xfer && (in_sel == PATH_MEM);

    alu_demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_fill       (w_fill0),
        .i_ready      (out0_ready),
        .i_data       (in_data),
        .o_valid      (out0_valid),
        .o_data       (out0_data),
        .o_can_accept (w_acc0)
    );

    alu_demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_fill       (w_fill1),
        .i_ready      (out1_ready),
        .i_data       (in_data),
        .o_valid      (out1_valid),
        .o_data       (out1_data),
        .o_can_accept (w_acc1)
    );

endmodule

// File: doc/alu_result_demux.md
# alu_result_demux

Routes each 32-bit ALU result to one of two downstream consumers, selected per word. Path 0 is register-file writeback; path 1 is the memory-address/store path. Each path has a one-entry registered output slot with an independent valid/ready handshake, so one stalled consumer never blocks the other. The block sits between the ALU output and the EX/MEM boundary of the pipeline, after the ALU's 2:1 operand selection.

## Interface
- WIDTH, 32, data width of every result word.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous pipeline flush; discards both slots.
- in_valid  input  1  ALU result present.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- in_sel  input  1  destination: 0 = path 0 (writeback), 1 = path 1 (memory).
- in_data  input  WIDTH  result word.
- out0_valid / out1_valid  output  1  slot N holds a word.
- out0_ready / out1_ready  input  1  consumer N takes the word.
- out0_data / out1_data  output  WIDTH  slot N contents.

## Operation
- Each slot has two states: EMPTY and FULL.
- Slot N drains when outN_valid && outN_ready. FULL→EMPTY on drain without a refill.
- Slot N fills when an input is accepted with in_sel == N. EMPTY→FULL on fill. FULL→FULL on simultaneous drain and fill, with data replaced by in_data.
- in_ready = !flush && (slot[in_sel] EMPTY || slot[in_sel] draining this cycle). in_ready is combinational from in_sel, flush and outN_ready. It does not depend on in_valid.
- The unselected slot is never written by an input transfer.
- Order is preserved within a path only. Words on different paths can be consumed in any relative order.
- Flush (cycle-synchronous): both slots go EMPTY at the next edge, and in_ready = 0 that cycle, so no input is accepted. A consumer handshake completing in the flush cycle still counts as delivered.
- Data registers load only on a fill. They hold their value when EMPTY and are not checked while EMPTY.
- Reset: outN_valid = 0, outN_data = 0, in_ready follows the combinational rule (1 once rst_n is high and flush is low).
- Reset asserted mid-transfer: both slots are emptied immediately. A word in flight is lost. No recovery is required.

## Timing
- Latency: a word accepted at edge k is on outN_data with outN_valid = 1 after edge k.
- Throughput: one word per cycle per path when that consumer holds ready high. This is sustained even with back-to-back words on the same path, because of the drain-and-fill rule.
- No combinational path from in_valid or in_data to any output.
- outN_valid and outN_data are stable while outN_valid && !outN_ready, unless flush or reset occurs.

## Structure
- Shared package:
  - WIDTH default (32).
  - Path encoding constants PATH_WB = 1'b0 and PATH_MEM = 1'b1.
  - Slot state encoding SLOT_EMPTY / SLOT_FULL.
- Sub-module alu_demux_slot: one valid/data register with fill, drain and flush inputs, exporting can_accept (EMPTY or draining). It is instantiated twice.
- The top level holds:
  - the in_sel decode into per-slot fill enables;
  - the in_ready mux between the two slots' can_accept.

## Test plan
- Reset with rst_n low while out0_ready = out1_ready = 0 → both outN_valid = 0 and outN_data = 0. Release reset, drive in_valid = 0 → in_ready = 1.
- Single word to each path: sel 0 with 0x0000_1234, next cycle sel 1 with 0xDEAD_BEEF, both consumers ready → out0 shows 0x1234 one cycle after acceptance, out1 shows 0xDEADBEEF one cycle after its acceptance.
- Stalled path 0 (out0_ready = 0) holding 0x11 → a new sel 0 word sees in_ready = 0 and out0_data stays 0x11. A sel 1 word 0x22 is accepted and appears on out1.
- Back-to-back sel 1 words 1, 2, 3, 4 with out1_ready = 1 → in_ready is high every cycle and out1 shows 1, 2, 3, 4 on consecutive cycles.
- Flush with both slots FULL and in_valid = 1 → in_ready = 0 that cycle, and both outN_valid = 0 next cycle. The input word is not accepted.
- Reset asserted while slot 1 is FULL with out1_ready = 0 → out1_valid drops immediately without waiting for a clock edge. The slot is EMPTY after reset is released.
